// File: rtl/idea_key_expander.sv
`timescale 1ns/1ps
// Purpose : IDEA encryption key schedule; 128-bit master key -> Z1..Z52, eight subkeys per clock.
// Latency : start edge T, groups written on edges T+1..T+7, done pulses for the cycle after T+7.
// Backpressure: none; start is only honoured in IDLE, ignored (not queued) while EXPAND/DONE.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   start, key        expansion request and master key (key[127:112] becomes Z1)
//   busy              high in EXPAND
//   done              one-cycle pulse in DONE
//   keysListValid     high from done until the next accepted start
//   keysList          Zi at keysList[(i-1)*16 +: 16]; bits 895:832 stay zero
module idea_key_expander #(
  parameter int NUM_SUBKEYS = 52,
  parameter int ROT         = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         keysListValid,
  output logic [895:0] keysList
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   kreg_q, kreg_d;
  logic [2:0]     grp_q, grp_d;
  logic           valid_q, valid_d;
  logic [895:0]   keys_q, keys_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kreg_q  <= '0;
      grp_q   <= '0;
      valid_q <= 1'b0;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      grp_q   <= grp_d;
      valid_q <= valid_d;
      keys_q  <= keys_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    grp_d   = grp_q;
    valid_d = valid_q;
    keys_d  = keys_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          kreg_d  = key;
          grp_d   = 3'd0;
          valid_d = 1'b0;
          state_d = S_EXPAND;
        end
      end

      S_EXPAND: begin
        // Word j of the key register is the j-th 16-bit slice counted from the MSB.
        // The last group only has four live subkeys; the remainder fall outside 52.
        for (int j = 0; j < 8; j++) begin
          int idx;
          idx = int'(grp_q) * 8 + j;
          if (idx < NUM_SUBKEYS) begin
            keys_d[idx*16 +: 16] = kreg_q[127 - 16*j -: 16];
          end
        end
        kreg_d = (kreg_q << ROT) | (kreg_q >> (128 - ROT));
        grp_d  = grp_q + 3'd1;
        if (grp_q == 3'd6) begin
          // Raise valid together with entry into DONE so it is high while done pulses.
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy          = (state_q == S_EXPAND);
  assign done          = (state_q == S_DONE);
  assign keysListValid = valid_q;
  assign keysList      = keys_q;

endmodule

// File: tb/tb_idea_key_expander.sv
`timescale 1ns/1ps
module tb_idea_key_expander;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic         keys_list_valid;
  logic [895:0] keys_list;

  int ncheck = 0;
  int nfail  = 0;

  localparam logic [127:0] KEY_A    = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [127:0] KEY_ONES = {128{1'b1}};
  localparam logic [127:0] KEY_BIT0 = {1'b1, 127'b0};

  idea_key_expander dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .key           (key),
    .busy          (busy),
    .done          (done),
    .keysListValid (keys_list_valid),
    .keysList      (keys_list)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: subkey i (0-based) is the 16 key bits starting at MSB-first position
  // 16*(i mod 8) + 25*(i div 8), wrapping modulo 128.
  function automatic logic [895:0] model(input logic [127:0] k);
    logic [895:0] r;
    r = '0;
    for (int i = 0; i < 52; i++) begin
      for (int b = 0; b < 16; b++) begin
        int pos;
        pos = (16 * (i % 8) + 25 * (i / 8) + b) % 128;
        r[i*16 + 15 - b] = k[127 - pos];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] zword(input logic [895:0] l, input int i);
    return l[(i-1)*16 +: 16];
  endfunction

  // Runs one expansion from IDLE; optionally pulses start with another key at cycle inj_cyc.
  task automatic run_expand(input logic [127:0] k, input int inj_cyc, input logic [127:0] inj_key,
                            output int done_lat, output int busy_cyc, output int done_cnt);
    done_lat = -1;
    busy_cyc = 0;
    done_cnt = 0;
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = 128'($urandom) ^ {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 20; c++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_lat < 0) done_lat = c;
      end
      if (c == inj_cyc) begin
        start = 1'b1;
        key   = inj_key;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    key   = '0;
    #12;
    ncheck++;
    if ({busy, done, keys_list_valid} !== 3'b000) begin
      nfail++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, keys_list_valid});
    end
    ncheck++;
    if (keys_list !== '0) begin
      nfail++;
      $display("FAIL reset_list: got %h want 0", keys_list);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ncheck++;
    if ({busy, done, keys_list_valid} !== 3'b000 || keys_list !== '0) begin
      nfail++;
      $display("FAIL idle_after_reset: flags %b list %h", {busy, done, keys_list_valid}, keys_list);
    end
  endtask

  task automatic test_vector_a;
    logic [15:0] exp_tbl [24];
    int lat, bc, dc;
    exp_tbl = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008,
                16'h0400, 16'h0600, 16'h0800, 16'h0A00, 16'h0C00, 16'h0E00, 16'h1000, 16'h0200,
                16'h0010, 16'h0014, 16'h0018, 16'h001C, 16'h0020, 16'h0004, 16'h0008, 16'h000C};
    run_expand(KEY_A, -1, '0, lat, bc, dc);
    ncheck++;
    if (lat !== 7) begin
      nfail++;
      $display("FAIL vecA_done_latency: got %0d want 7 cycles after start edge", lat);
    end
    for (int i = 1; i <= 24; i++) begin
      ncheck++;
      if (zword(keys_list, i) !== exp_tbl[i-1]) begin
        nfail++;
        $display("FAIL vecA_Z%0d: got %h want %h", i, zword(keys_list, i), exp_tbl[i-1]);
      end
    end
    ncheck++;
    if (keys_list[895:832] !== 64'h0) begin
      nfail++;
      $display("FAIL vecA_pad: got %h want 0", keys_list[895:832]);
    end
    ncheck++;
    if (keys_list !== model(KEY_A)) begin
      nfail++;
      $display("FAIL vecA_full: got %h want %h", keys_list, model(KEY_A));
    end
  endtask

  task automatic test_single_bit;
    int lat, bc, dc;
    logic [15:0] want;
    run_expand(KEY_BIT0, -1, '0, lat, bc, dc);
    for (int i = 1; i <= 24; i++) begin
      want = (i == 1) ? 16'h8000 : (i == 15) ? 16'h0100 : (i == 21) ? 16'h0002 : 16'h0000;
      ncheck++;
      if (zword(keys_list, i) !== want) begin
        nfail++;
        $display("FAIL bit0_Z%0d: got %h want %h", i, zword(keys_list, i), want);
      end
    end
    ncheck++;
    if (keys_list_valid !== 1'b1) begin
      nfail++;
      $display("FAIL bit0_valid: got %b want 1", keys_list_valid);
    end
  endtask

  task automatic test_all_ones;
    int lat, bc, dc;
    logic [895:0] want;
    want = {64'h0, {832{1'b1}}};
    run_expand(KEY_ONES, -1, '0, lat, bc, dc);
    ncheck++;
    if (keys_list !== want) begin
      nfail++;
      $display("FAIL ones_list: got %h want %h", keys_list, want);
    end
    ncheck++;
    if (bc !== 7) begin
      nfail++;
      $display("FAIL ones_busy_cycles: got %0d want 7", bc);
    end
    ncheck++;
    if (dc !== 1) begin
      nfail++;
      $display("FAIL ones_done_cycles: got %0d want 1", dc);
    end
  endtask

  task automatic test_random;
    int lat, bc, dc;
    logic [127:0] k;
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_expand(k, -1, '0, lat, bc, dc);
      ncheck++;
      if (keys_list !== model(k) || lat !== 7 || dc !== 1) begin
        nfail++;
        $display("FAIL random_%0d: key %h got %h lat %0d dones %0d want %h lat 7 dones 1",
                 n, k, keys_list, lat, dc, model(k));
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat, bc, dc;
    run_expand(KEY_A, 2, KEY_ONES, lat, bc, dc);
    ncheck++;
    if (keys_list !== model(KEY_A)) begin
      nfail++;
      $display("FAIL ignore_result: got %h want %h", keys_list, model(KEY_A));
    end
    ncheck++;
    if (dc !== 1) begin
      nfail++;
      $display("FAIL ignore_done_count: got %0d want 1", dc);
    end
  endtask

  task automatic test_back_to_back;
    int seen;
    @(negedge clk);
    key   = KEY_A;
    start = 1'b1;
    repeat (8) @(negedge clk);
    ncheck++;
    if (done !== 1'b1) begin
      nfail++;
      $display("FAIL held_done: got %b want 1 after edge T+7", done);
    end
    key = KEY_ONES;
    @(negedge clk);
    ncheck++;
    if (busy !== 1'b0 || keys_list_valid !== 1'b1) begin
      nfail++;
      $display("FAIL held_idle: busy %b valid %b want 0 1", busy, keys_list_valid);
    end
    @(negedge clk);
    ncheck++;
    if (busy !== 1'b1 || keys_list_valid !== 1'b0) begin
      nfail++;
      $display("FAIL held_accept: busy %b valid %b want 1 0", busy, keys_list_valid);
    end
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    ncheck++;
    if (seen != 1 || keys_list !== model(KEY_ONES)) begin
      nfail++;
      $display("FAIL held_second_result: done_seen %0d got %h want %h", seen, keys_list, model(KEY_ONES));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bc, dc;
    @(negedge clk);
    key   = KEY_BIT0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    ncheck++;
    if ({busy, done, keys_list_valid} !== 3'b000 || keys_list !== '0) begin
      nfail++;
      $display("FAIL midreset_clear: flags %b list %h want 000 and 0", {busy, done, keys_list_valid}, keys_list);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_expand(KEY_A, -1, '0, lat, bc, dc);
    ncheck++;
    if (keys_list !== model(KEY_A) || dc !== 1) begin
      nfail++;
      $display("FAIL midreset_restart: got %h dones %0d want %h dones 1", keys_list, dc, model(KEY_A));
    end
  endtask

  initial begin
    test_reset();
    test_vector_a();
    test_single_bit();
    test_all_ones();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule
